// File: rtl/map_pkg.sv
// Shared map geometry, edit opcodes and edit-sequencer states for the tile-map
// edit path.
package map_pkg;

    localparam int unsigned MAP_W = 128;
    localparam int unsigned MAP_H = 64;

    typedef enum logic [1:0] {OP_NONE, OP_BREAK, OP_PLACE, OP_RSVD} map_op_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the grant goes to the first requester at or after
// last+1, wrapping past N_REQ-1.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    int unsigned      k;
    logic [IDX_W-1:0] k_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        k_idx   = '0;
        // Offsets 1..N_REQ visit last+1 first and last itself at the very end.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            k     = (32'(last) + i) % N_REQ;
            k_idx = IDX_W'(k);
            if (!found && req[k_idx]) begin
                found      = 1'b1;
                gnt[k_idx] = 1'b1;
                gnt_idx    = k_idx;
            end
        end
    end

endmodule

// File: rtl/map_edit_arbiter.sv
// Arbitrates block-edit requests onto the tile-map edit port. It range-checks each
// request and then times the hold and gap phases of every edit.
module map_edit_arbiter
    import map_pkg::map_op_t, map_pkg::state_t, map_pkg::OP_NONE, map_pkg::OP_BREAK,
           map_pkg::OP_PLACE, map_pkg::S_IDLE, map_pkg::S_ISSUE, map_pkg::S_GAP;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned MAP_W      = map_pkg::MAP_W,
    parameter int unsigned MAP_H      = map_pkg::MAP_H,
    parameter int unsigned OP_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*10-1:0] req_x,
    input  logic [N_REQ*10-1:0] req_y,
    input  logic [N_REQ*2-1:0]  req_op,
    input  logic [N_REQ*4-1:0]  req_id,
    input  logic                lock,
    output logic [9:0]          changex,
    output logic [9:0]          changey,
    output logic [1:0]          operation,
    output logic [3:0]          push_id,
    output logic                busy,
    output logic                err_valid,
    output logic [2:0]          err_src
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    map_op_t          op_q, op_d;
    logic [3:0]       id_q, id_d;
    logic             err_valid_q, err_valid_d;
    logic [2:0]       err_src_q, err_src_d;

    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             grant_en, accept, legal;
    logic [9:0]       sel_x, sel_y;
    logic [1:0]       sel_op;
    logic [3:0]       sel_id;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign grant_en  = (state_q == S_IDLE) && !lock;
    assign req_ready = grant_en ? gnt : '0;
    assign accept    = grant_en && (|gnt);

    // One-hot mux of the winner's payload.
    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_op = '0;
        sel_id = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                sel_x  = req_x[10*i +: 10];
                sel_y  = req_y[10*i +: 10];
                sel_op = req_op[2*i +: 2];
                sel_id = req_id[4*i +: 4];
            end
        end
    end

    assign legal = (32'(sel_x) < MAP_W) && (32'(sel_y) < MAP_H) &&
                   ((sel_op == OP_BREAK) || (sel_op == OP_PLACE));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        x_d         = x_q;
        y_d         = y_q;
        op_d        = op_q;
        id_d        = id_q;
        err_valid_d = 1'b0;
        err_src_d   = err_src_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    last_d = gnt_idx;
                    if (legal) begin
                        x_d     = sel_x;
                        y_d     = sel_y;
                        op_d    = map_op_t'(sel_op);
                        id_d    = (sel_op == OP_PLACE) ? sel_id : 4'd0;
                        cnt_d   = 3'(OP_CYCLES - 1);
                        state_d = S_ISSUE;
                    end else begin
                        // The request is consumed; the requester only sees the error pulse.
                        err_valid_d = 1'b1;
                        err_src_d   = 3'(gnt_idx);
                    end
                end
            end
            S_ISSUE: begin
                if (cnt_q == 3'd0) begin
                    op_d    = OP_NONE;
                    cnt_d   = 3'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            x_q         <= '0;
            y_q         <= '0;
            op_q        <= OP_NONE;
            id_q        <= '0;
            err_valid_q <= 1'b0;
            err_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            x_q         <= x_d;
            y_q         <= y_d;
            op_q        <= op_d;
            id_q        <= id_d;
            err_valid_q <= err_valid_d;
            err_src_q   <= err_src_d;
        end
    end

    assign changex   = x_q;
    assign changey   = y_q;
    assign operation = op_q;
    assign push_id   = id_q;
    assign busy      = (state_q != S_IDLE);
    assign err_valid = err_valid_q;
    assign err_src   = err_src_q;

endmodule

// File: tb/tb_map_edit_arbiter.sv
// Randomized scoreboard bench for map_edit_arbiter: a timestamp-based reference model
// predicts grants, edit timing, and the queued write/error responses.
module tb_map_edit_arbiter;

    localparam int N    = 3;
    localparam int OPC  = 2;
    localparam int GAPC = 2;
    localparam int MW   = 128;
    localparam int MH   = 64;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*10-1:0] req_x = '0;
    logic [N*10-1:0] req_y = '0;
    logic [N*2-1:0]  req_op = '0;
    logic [N*4-1:0]  req_id = '0;
    logic            lock = 1'b0;
    logic [9:0]      changex, changey;
    logic [1:0]      operation;
    logic [3:0]      push_id;
    logic            busy, err_valid;
    logic [2:0]      err_src;

    always #5 Clk = ~Clk;

    map_edit_arbiter #(
        .N_REQ      (N),
        .MAP_W      (MW),
        .MAP_H      (MH),
        .OP_CYCLES  (OPC),
        .GAP_CYCLES (GAPC)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_op    (req_op),
        .req_id    (req_id),
        .lock      (lock),
        .changex   (changex),
        .changey   (changey),
        .operation (operation),
        .push_id   (push_id),
        .busy      (busy),
        .err_valid (err_valid),
        .err_src   (err_src)
    );

    typedef struct {
        bit is_err;
        int src;
        int x;
        int y;
        int op;
        int id;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Requester-side stimulus state
    bit         pend[N];
    logic [9:0] px[N];
    logic [9:0] py[N];
    logic [1:0] pop[N];
    logic [3:0] pid[N];
    logic [N-1:0] hs_q = '0;
    bit gen_en = 1'b1;
    bit lock_en = 1'b0;
    int rate = 1;

    // Reference model state (timestamps in cycles)
    int cyc = 0;
    int free_at = 0;
    int last_acc = 0;
    bit acc_seen = 1'b0;
    int last_op = 0;
    int err_at = -1;
    int mlast = N - 1;
    logic [1:0] prev_op = '0;
    int exp_op;
    logic [N-1:0] exp_rdy;
    int w;
    bit legal;
    exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_x[10*i +: 10]  = px[i];
            req_y[10*i +: 10]  = py[i];
            req_op[2*i +: 2]   = pop[i];
            req_id[4*i +: 4]   = pid[i];
        end
    endtask

    task automatic new_req(input int i);
        int r;
        r = int'($urandom % 8);
        if (r == 0)
            px[i] = ($urandom % 2 == 0) ? 10'(MW) : 10'($urandom_range(MW, 1023));
        else
            px[i] = ($urandom % 4 == 0) ? 10'(MW - 1) : 10'($urandom_range(0, MW - 1));
        if (r == 1)
            py[i] = ($urandom % 2 == 0) ? 10'(MH) : 10'($urandom_range(MH, 1023));
        else
            py[i] = ($urandom % 4 == 0) ? 10'(MH - 1) : 10'($urandom_range(0, MH - 1));
        if (r == 2)
            pop[i] = ($urandom % 2 == 0) ? 2'd0 : 2'd3;
        else
            pop[i] = ($urandom % 2 == 0) ? 2'd1 : 2'd2;
        pid[i]  = 4'($urandom);
        pend[i] = 1'b1;
    endtask

    // Advance one cycle: retire handshaken requests, maybe raise new ones, move lock.
    task automatic step();
        @(posedge Clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i]) pend[i] = 1'b0;
            if (!pend[i] && gen_en && ($urandom % rate == 0)) new_req(i);
        end
        pack();
        if (lock_en) begin
            if ($urandom % 6 == 0) lock = ~lock;
        end else begin
            lock = 1'b0;
        end
    endtask

    task automatic model_reset();
        free_at  = 0;
        acc_seen = 1'b0;
        err_at   = -1;
        mlast    = N - 1;
        prev_op  = '0;
        q.delete();
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            model_reset();
            hs_q = '0;
        end else begin
            exp_op = (acc_seen && cyc > last_acc && cyc <= last_acc + OPC) ? last_op : 0;
            check("operation", 32'(operation), 32'(exp_op));
            check("busy", 32'(busy), 32'(cyc < free_at));
            check("err_valid", 32'(err_valid), 32'(cyc == err_at));

            if (err_valid) begin
                check("err_queue_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("err_expected_kind", 32'(e.is_err), 32'd1);
                    check("err_src", 32'(err_src), 32'(e.src));
                end
            end

            if (operation != 2'd0 && prev_op == 2'd0) begin
                check("write_queue_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("write_expected_kind", 32'(e.is_err), 32'd0);
                    check("write_op", 32'(operation), 32'(e.op));
                    check("changex", 32'(changex), 32'(e.x));
                    check("changey", 32'(changey), 32'(e.y));
                    check("push_id", 32'(push_id), 32'(e.id));
                end
            end
            prev_op = operation;

            exp_rdy = '0;
            w = -1;
            if (cyc >= free_at && !lock) begin
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && req_valid[(mlast + k) % N]) w = (mlast + k) % N;
                end
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));

            if (w >= 0) begin
                legal = (int'(px[w]) < MW) && (int'(py[w]) < MH) &&
                        (pop[w] == 2'd1 || pop[w] == 2'd2);
                e.src = w;
                e.x   = int'(px[w]);
                e.y   = int'(py[w]);
                e.op  = int'(pop[w]);
                e.id  = (pop[w] == 2'd2) ? int'(pid[w]) : 0;
                if (legal) begin
                    e.is_err = 1'b0;
                    last_acc = cyc;
                    acc_seen = 1'b1;
                    last_op  = int'(pop[w]);
                    free_at  = cyc + OPC + GAPC + 1;
                end else begin
                    e.is_err = 1'b1;
                    err_at   = cyc + 1;
                end
                q.push_back(e);
                mlast = w;
            end
            hs_q = req_valid & req_ready;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            px[i] = '0;
            py[i] = '0;
            pop[i] = '0;
            pid[i] = '0;
        end
        // First edit out of reset: requester 0 breaks (5,7); the id must not reach push_id.
        pend[0] = 1'b1;
        px[0] = 10'd5;
        py[0] = 10'd7;
        pop[0] = 2'd1;
        pid[0] = 4'd9;
        gen_en = 1'b0;
        pack();
        repeat (3) @(posedge Clk);
        #1;
        check("reset_changex", 32'(changex), 32'd0);
        check("reset_operation", 32'(operation), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err_valid", 32'(err_valid), 32'd0);
        check("reset_push_id", 32'(push_id), 32'd0);
        Reset_n = 1'b1;
        repeat (6) step();

        // Saturated requesters: round-robin order and throughput.
        gen_en = 1'b1;
        rate = 1;
        repeat (400) step();

        // Sparse traffic with lock toggling.
        rate = 4;
        lock_en = 1'b1;
        repeat (800) step();
        lock_en = 1'b0;
        rate = 1;

        // Reset in the middle of an edit.
        n = 0;
        step();
        while (operation == 2'd0 && n < 200) begin
            step();
            n++;
        end
        check("edit_seen_before_reset", 32'(operation != 2'd0), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset_operation", 32'(operation), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_changex", 32'(changex), 32'd0);
        check("async_reset_changey", 32'(changey), 32'd0);
        check("async_reset_push_id", 32'(push_id), 32'd0);
        repeat (2) step();
        Reset_n = 1'b1;
        repeat (300) step();

        // Drain outstanding requests and responses.
        gen_en = 1'b0;
        n = 0;
        while (n < 300 && (pend[0] || pend[1] || pend[2] || q.size() != 0 || busy)) begin
            step();
            n++;
        end
        repeat (3) step();
        check("drain_queue_empty", 32'(q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/map_edit_arbiter.md
# map_edit_arbiter

Sequences block-edit requests (break/place) from several game requesters (player input, physics, scripted events) onto the single edit port of the tile-map RAM. It round-robin arbitrates, range-checks coordinates, and drives `changex`/`changey`/`operation`/`push_id` with exactly the hold and gap timing the map's hold→set→write edit FSM needs. There is one write per grant and no double-writes. It sits between the requester logic and the map module.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters, 2..8.
- `MAP_W`, default 128: map width in tiles (4 chunks × 32).
- `MAP_H`, default 64: map height in tiles (11-bit `waddr` = y*32 + x%32).
- `OP_CYCLES`, default 2: cycles `operation` is held nonzero per edit.
- `GAP_CYCLES`, default 2: cycles `operation` is held at 0 after each edit (minimum 2).

Ports:
- `Clk` in, 1: system clock, rising edge.
- `Reset_n` in, 1: asynchronous, active-low reset.
- `req_valid` in, N_REQ: per-requester edit request.
- `req_ready` out, N_REQ: one-hot grant; a transfer happens when `req_valid[i] && req_ready[i]`.
- `req_x` in, N_REQ*10: tile x, requester i occupies bits [10i+9:10i].
- `req_y` in, N_REQ*10: tile y, same packing as `req_x`.
- `req_op` in, N_REQ*2: 1 = break, 2 = place; 0 and 3 are illegal.
- `req_id` in, N_REQ*4: block id for place; ignored for break.
- `lock` in, 1: while high, no new grants are issued.
- `changex`, `changey` out, 10 each: registered edit coordinates.
- `operation` out, 2: edit command to the map.
- `push_id` out, 4: registered block id.
- `busy` out, 1: high whenever state ≠ IDLE.
- `err_valid` out, 1: one-cycle pulse when a request is rejected.
- `err_src` out, 3: index of the rejected requester.

## Operation
- States:
  - IDLE: `operation` = 0. If `lock` = 0 and any `req_valid` is high, `req_ready` goes high combinationally for the round-robin winner (search starts at `last+1` mod N_REQ). On handshake, the request is checked.
  - Valid request (`req_x` < MAP_W, `req_y` < MAP_H, `req_op` ∈ {1,2}):
    - latch x, y, and the id into the output registers;
    - `push_id` is forced to 0 for a break;
    - `last` ← winner;
    - go to ISSUE.
  - Invalid request: the request is consumed; `err_valid` = 1 and `err_src` = winner on the next cycle; `last` ← winner; stay in IDLE.
  - ISSUE: `operation` = latched op for OP_CYCLES cycles, then go to GAP.
  - GAP: `operation` = 0 for GAP_CYCLES cycles, then go to IDLE.
- `req_ready` is 0 in ISSUE and GAP and while `lock` = 1.
- `lock` rising mid-edit does not abort the edit in flight; it only blocks the next grant.
- `changex`, `changey`, and `push_id` hold their values until the next accepted valid request.
- A single down-counter (3 bits) times ISSUE and GAP.
- Reset values:
  - state = IDLE, `last` = N_REQ-1 (requester 0 wins first);
  - `changex` = `changey` = 0, `operation` = 0, `push_id` = 0;
  - `busy` = 0, `err_valid` = 0, `err_src` = 0.
- Reset mid-edit: all outputs clear immediately and asynchronously. A partial edit in the map is tolerated; the requester must retry.

## Timing
- Accept at cycle T.
- `operation` ≠ 0 in T+1..T+OP_CYCLES.
- `operation` = 0 in T+OP_CYCLES+1..T+OP_CYCLES+GAP_CYCLES.
- Next accept is possible at T+OP_CYCLES+GAP_CYCLES+1 (T+5 with the defaults).
- Sustained throughput: one edit per 5 cycles.
- A rejected request at T can be followed by another accept at T+1.
- `req_valid` must stay high, with stable payload, until `req_ready` is seen; dropping it early is a requester error.
- Simultaneous valids: the winner is the first set bit at or after `last+1`, with wrap-around past N_REQ-1.

## Structure
- `map_pkg` holds:
  - `MAP_W` and `MAP_H`;
  - `typedef enum logic [1:0] {OP_NONE, OP_BREAK, OP_PLACE, OP_RSVD} map_op_t`;
  - the state enum `{S_IDLE, S_ISSUE, S_GAP}`.
- One sub-module, `rr_arbiter` (N_REQ, inputs `req` and `last`, outputs one-hot `gnt` and index `gnt_idx`), is purely combinational.
- `map_edit_arbiter` contains the FSM, counter, range check, and output registers.

## Test plan
- Reset release, requester 0 issues a break at (5,7): `req_ready[0]` is high at T; `operation` = 1 at T+1..T+2 and 0 at T+3..T+4; `changex` = 5, `changey` = 7, `push_id` = 0.
- Requesters 0, 1, 2 all hold valid places: grants go 0, 1, 2, 0 at cycles T, T+5, T+10, T+15, and each place drives its own `push_id`.
- Requester 1 requests x = 128 with op = 2: handshake completes at T, `err_valid` = 1 and `err_src` = 1 at T+1, `operation` stays 0; a valid request from requester 2 is accepted at T+1.
- `req_op` = 3 or `req_y` = 64: the request is rejected with an err pulse, and no write is issued.
- `lock` asserted at T+2 during an edit: the edit completes (`operation` high for 2 cycles), then no grant is given until `lock` falls; after that the next grant follows round-robin order.
- `Reset_n` pulled low at T+1 of an edit: `operation`, `busy`, and the coordinates go to 0 immediately; after release, requester 0 wins first.
